// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one 64-bit add/sub/and/xor ALU.
// One operation outstanding; result held until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_of,
    output logic             rsp_zf,
    output logic             rsp_sf
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_id;
    logic [WIDTH-1:0] r_out;
    logic             r_of;
    logic             r_zf;
    logic             r_sf;

    logic             w_open;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [1:0]       w_fn;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_of;

    // Reset gates the grants so nothing is accepted in a reset cycle.
    assign w_open   = (r_state == IDLE) && !rst;
    assign w_gnt0   = w_open && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1   = w_open && req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_fn = w_gnt1 ? req1_fn : req0_fn;
    assign w_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_b  = w_gnt1 ? req1_b  : req0_b;

    assign w_sum = w_a + w_b;
    assign w_dif = w_a - w_b;

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        unique case (w_fn)
            2'd0: begin
                w_res = w_sum;
                w_of  = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            2'd1: begin
                w_res = w_dif;
                w_of  = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                        (w_dif[WIDTH-1] != w_a[WIDTH-1]);
            end
            2'd2: w_res = w_a & w_b;
            2'd3: w_res = w_a ^ w_b;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nxt = BUSY;
            BUSY: if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_out        <= '0;
            r_of         <= 1'b0;
            r_zf         <= 1'b0;
            r_sf         <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt1;
            r_id         <= w_gnt1;
            r_out        <= w_res;
            r_of         <= w_of;
            r_zf         <= (w_res == '0);
            r_sf         <= w_res[WIDTH-1];
        end
    end

    assign rsp_valid = (r_state == BUSY);
    assign rsp_id    = r_id;
    assign rsp_out   = r_out;
    assign rsp_of    = r_of;
    assign rsp_zf    = r_zf;
    assign rsp_sf    = r_sf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration, ALU results, flags,
// backpressure and reset behaviour.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_fn;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_fn;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_out;
    logic        rsp_of;
    logic        rsp_zf;
    logic        rsp_sf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_fn    (req0_fn),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_fn    (req1_fn),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_of     (rsp_of),
        .rsp_zf     (rsp_zf),
        .rsp_sf     (rsp_sf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the full response bundle against expected values.
    task automatic chk_rsp(input string tag, input logic v, input logic id,
                           input logic [63:0] o, input logic of,
                           input logic zf, input logic sf);
        chk({tag, ".valid"}, 64'(rsp_valid), 64'(v));
        chk({tag, ".id"},    64'(rsp_id),    64'(id));
        chk({tag, ".out"},   rsp_out,        o);
        chk({tag, ".of"},    64'(rsp_of),    64'(of));
        chk({tag, ".zf"},    64'(rsp_zf),    64'(zf));
        chk({tag, ".sf"},    64'(rsp_sf),    64'(sf));
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_fn    = 2'd0;
        req0_a     = '0;
        req0_b     = '0;
        req1_valid = 1'b1;
        req1_fn    = 2'd0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b0;

        step();
        chk("rst_rdy0", 64'(req0_ready), 64'd0);
        chk("rst_rdy1", 64'(req1_ready), 64'd0);
        chk_rsp("rst", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // First tie after reset goes to requester 0.
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req0_fn   = 2'd3;
        req0_a    = 64'hFF00FF00FF00FF00;
        req0_b    = 64'h0F0F0F0F0F0F0F0F;
        req1_fn   = 2'd1;
        req1_a    = 64'd5;
        req1_b    = 64'd7;
        #1;
        chk("xor_rdy0", 64'(req0_ready), 64'd1);
        chk("xor_rdy1", 64'(req1_ready), 64'd0);
        step();
        chk_rsp("xor", 1'b1, 1'b0, 64'hF00FF00FF00FF00F, 1'b0, 1'b0, 1'b1);
        chk("busy_rdy0", 64'(req0_ready), 64'd0);
        chk("busy_rdy1", 64'(req1_ready), 64'd0);
        step();

        // Both held valid: grants alternate 1,0,1,0.
        req0_fn = 2'd2;
        req0_a  = 64'hF0;
        req0_b  = 64'h3C;
        for (int i = 0; i < 4; i++) begin
            #0;
            if (i % 2 == 0) begin
                chk("rr_rdy0", 64'(req0_ready), 64'd0);
                chk("rr_rdy1", 64'(req1_ready), 64'd1);
                step();
                chk_rsp("rr_sub", 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE,
                        1'b0, 1'b0, 1'b1);
            end else begin
                chk("rr_rdy0", 64'(req0_ready), 64'd1);
                chk("rr_rdy1", 64'(req1_ready), 64'd0);
                step();
                chk_rsp("rr_and", 1'b1, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
            end
            step();
            chk("rr_idle", 64'(rsp_valid), 64'd0);
        end

        // Signed overflow cases on requester 1.
        req0_valid = 1'b0;
        req1_fn    = 2'd0;
        req1_a     = 64'h7FFFFFFFFFFFFFFF;
        req1_b     = 64'd1;
        #1;
        chk("add_rdy1", 64'(req1_ready), 64'd1);
        step();
        chk_rsp("add_of", 1'b1, 1'b1, 64'h8000000000000000, 1'b1, 1'b0, 1'b1);
        step();
        req1_fn = 2'd1;
        req1_a  = 64'h8000000000000000;
        req1_b  = 64'd1;
        #1;
        chk("sub_rdy1", 64'(req1_ready), 64'd1);
        step();
        chk_rsp("sub_of", 1'b1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
        req1_valid = 1'b0;
        step();
        chk_rsp("retain", 1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);

        // Zero result held under backpressure for five cycles.
        req0_valid = 1'b1;
        req0_fn    = 2'd3;
        req0_a     = 64'h123456789ABCDEF0;
        req0_b     = 64'h123456789ABCDEF0;
        rsp_ready  = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk_rsp("hold", 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
            chk("hold_rdy0", 64'(req0_ready), 64'd0);
            chk("hold_rdy1", 64'(req1_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("drain_rdy0", 64'(req0_ready), 64'd0);
        step();
        chk("drain_valid", 64'(rsp_valid), 64'd0);
        chk("drain_rdy0n", 64'(req0_ready), 64'd1);

        // Reset while busy discards the held result.
        req0_fn = 2'd2;
        req0_a  = 64'hF0;
        req0_b  = 64'h3C;
        step();
        chk_rsp("pre_rst", 1'b1, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_fn    = 2'd0;
        req1_a     = 64'd2;
        req1_b     = 64'd3;
        rst        = 1'b1;
        #1;
        chk("rstb_rdy1", 64'(req1_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk_rsp("post_rst", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_rdy1", 64'(req1_ready), 64'd1);
        step();
        chk_rsp("post_add", 1'b1, 1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
        req1_valid = 1'b0;
        step();
        chk("end_idle", 64'(rsp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits; only 64 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_fn  input  2  requester 0 function: 0 add, 1 sub, 2 and, 3 xor.
REQ-007 req0_a, req0_b  input  64 each  requester 0 signed operands.
REQ-008 req1_valid, req1_ready, req1_fn, req1_a, req1_b  same widths/meanings as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result held on rsp_* is valid.
REQ-010 rsp_ready  input  1  consumer accepts result when high with rsp_valid.
REQ-011 rsp_id  output  1  index of requester that issued the held result.
REQ-012 rsp_out  output  64  signed result.
REQ-013 rsp_of, rsp_zf, rsp_sf  output  1 each  overflow, zero, sign flags of rsp_out.

Function
REQ-014 Block SHALL share one 64-bit ALU (add/sub/and/xor) between two requesters, one operation outstanding at a time.
REQ-015 FSM SHALL have two states: IDLE (no result held) and BUSY (result held, rsp_valid=1).
REQ-016 In IDLE, exactly one reqN_ready SHALL be high when at least one reqN_valid is high; both low otherwise; in BUSY both SHALL be low.
REQ-017 Arbitration in IDLE: single valid requester wins; if both valid, winner is the requester not recorded in last_grant (round-robin).
REQ-018 last_grant SHALL update to the winner's index only on an accepting cycle (valid & ready).
REQ-019 reqN_ready SHALL be combinational from reqN_valid, state and last_grant only; it SHALL NOT depend on fn or operands.
REQ-020 On accept in cycle N, the ALU result, flags and winner index SHALL be registered; rsp_valid SHALL be 1 from cycle N+1 (latency 1) and state becomes BUSY.
REQ-021 add: out = a + b mod 2^64; OF = 1 when a and b share a sign and out's sign differs.
REQ-022 sub: out = a - b mod 2^64; OF = 1 when a and b differ in sign and out's sign differs from a's.
REQ-023 and/xor: out = bitwise a&b / a^b; OF SHALL be 0.
REQ-024 zf = (out == 0); sf = out[63]; for all functions.
REQ-025 In BUSY, all rsp_* outputs SHALL hold stable until rsp_valid & rsp_ready.
REQ-026 On rsp_valid & rsp_ready in cycle M, state SHALL be IDLE and rsp_valid 0 in cycle M+1; a new accept is possible no earlier than M+1 (max throughput one op per 2 cycles).
REQ-027 Requester inputs changing while not accepted SHALL have no effect; a dropped reqN_valid before ready is not an error.
REQ-028 rsp_out, flags and rsp_id SHALL retain last values after return to IDLE until the next accept.

Reset
REQ-029 With rst high at a rising edge: state IDLE, rsp_valid 0, rsp_out 0, rsp_of/zf/sf 0, rsp_id 0, last_grant 1 (requester 0 wins first tie).
REQ-030 rst SHALL take priority over accept and response handshakes in the same cycle; a held BUSY result SHALL be discarded.
REQ-031 During the rst-high cycle both reqN_ready SHALL be 0, so no operation is accepted.

Verification
REQ-032 Both valid after reset, req0 xor a=0xFF00FF00FF00FF00 b=0x0F0F0F0F0F0F0F0F, rsp_ready=1 -> req0_ready=1, next cycle rsp_valid=1, rsp_id=0, rsp_out=0xF00FF00FF00FF00F, of=0, sf=1, zf=0.
REQ-033 Both held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 on every other cycle; no requester accepted twice in a row.
REQ-034 req1 add a=0x7FFFFFFFFFFFFFFF b=1 -> rsp_out=0x8000000000000000, of=1, sf=1; req1 sub a=0x8000000000000000 b=1 -> rsp_out=0x7FFFFFFFFFFFFFFF, of=1, sf=0.
REQ-035 req0 xor a=b=0x123456789ABCDEF0 with rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_out=0, zf=1 stable all 5 cycles, both reqN_ready=0; raise rsp_ready -> rsp_valid=0 next cycle.
REQ-036 rst asserted for one cycle while BUSY and req1_valid=1 -> next cycle rsp_valid=0, rsp_out=0, flags 0, no accept in reset cycle; following cycle req1 accepted.
REQ-037 rsp_valid & rsp_ready with req0_valid=1 in same cycle -> req0_ready=0 that cycle, req0_ready=1 the next.
